// File: rtl/seq_stim_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : seq_stim_pkg
//  Description : Shared state encoding and field widths for the serial
//                pattern transmitter.
//  Revision    : 1.0  initial release
// ============================================================================
package seq_stim_pkg;

    // Width of the repetition field on the load port.
    localparam int c_rep_w = 4;

    // Transmitter FSM states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/seq_stim_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_stim_tx_if
//  Description : Load port and serial output bundle of the pattern
//                transmitter. The producer of words uses 'master', the
//                transmitter itself uses 'slave'.
//  Revision    : 1.0  initial release
// ============================================================================
interface seq_stim_tx_if #(
    parameter int WIDTH = 8
);
    import seq_stim_pkg::*;

    logic                load_valid;
    logic                load_ready;
    logic [WIDTH-1:0]    load_data;
    logic [c_rep_w-1:0]  load_rep;
    logic                out;
    logic                out_valid;
    logic                busy;
    logic                done;

    modport master (
        output load_valid, load_data, load_rep,
        input  load_ready, out, out_valid, busy, done
    );

    modport slave (
        input  load_valid, load_data, load_rep,
        output load_ready, out, out_valid, busy, done
    );

endinterface
`default_nettype wire

// File: rtl/seq_stim_tx_piso_shreg.sv
`default_nettype none
// ============================================================================
//  Module      : piso_shreg
//  Description : WIDTH-bit parallel-load, shift-left register. Serial output
//                is the MSB; the bit below it is exposed so the owner can
//                register the upcoming bit in the same edge as the shift.
//  Revision    : 1.0  initial release
// ============================================================================
module piso_shreg #(
    parameter int WIDTH = 8
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load,
    input  wire logic             shift,
    input  wire logic [WIDTH-1:0] din,
    output logic                  dout,
    output logic                  dnext
);

    logic [WIDTH-1:0] sr_q;
    logic [WIDTH-1:0] sr_d;

    // Load has priority over shift; otherwise hold.
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din;
        end else if (shift) begin
            sr_d = {sr_q[WIDTH-2:0], 1'b0};
        end
    end

    // Register update.
    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign dout  = sr_q[WIDTH-1];
    assign dnext = sr_q[WIDTH-2];

endmodule
`default_nettype wire

// File: rtl/seq_stim_tx.sv
`default_nettype none
// ============================================================================
//  Module      : seq_stim_tx
//  Description : Serial pattern transmitter. Accepts a word on a valid/ready
//                port and sends it MSB-first load_rep+1 times, with GAP idle
//                cycles after each word. out/out_valid/done are registered;
//                busy/load_ready are decoded from the state register.
//  Revision    : 1.0  initial release
// ============================================================================
module seq_stim_tx
    import seq_stim_pkg::*;
#(
    parameter int   WIDTH    = 8,
    parameter int   GAP      = 0,
    parameter logic IDLE_BIT = 1'b0
) (
    input  wire logic     clk,
    input  wire logic     rst,
    seq_stim_tx_if.slave  bus
);

    localparam int c_bit_w = $clog2(WIDTH);
    localparam int c_gap_w = ($clog2(GAP + 1) > 1) ? $clog2(GAP + 1) : 1;

    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(WIDTH - 1);
    localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);
    localparam logic [c_gap_w-1:0] c_gap_last = c_gap_w'((GAP > 0) ? GAP - 1 : 0);
    localparam logic [c_gap_w-1:0] c_gap_one  = c_gap_w'(1);
    localparam logic [c_rep_w-1:0] c_rep_one  = c_rep_w'(1);

    state_t               state_q,     state_d;
    logic [c_bit_w-1:0]   bit_cnt_q,   bit_cnt_d;
    logic [c_gap_w-1:0]   gap_cnt_q,   gap_cnt_d;
    logic [c_rep_w-1:0]   rep_cnt_q,   rep_cnt_d;
    logic [WIDTH-1:0]     word_q,      word_d;
    logic                 final_q,     final_d;
    logic                 out_q,       out_d;
    logic                 out_valid_q, out_valid_d;
    logic                 done_q,      done_d;

    logic                 w_accept;
    logic                 w_sr_load;
    logic                 w_sr_shift;
    logic [WIDTH-1:0]     w_sr_din;
    logic                 w_sr_dout;
    logic                 w_sr_dnext;

    // Reset blocks acceptance so a simultaneous load_valid is never taken.
    assign bus.load_ready = (state_q == S_IDLE) && !rst;
    assign bus.busy       = (state_q != S_IDLE);
    assign w_accept       = bus.load_valid && bus.load_ready;

    piso_shreg #(
        .WIDTH (WIDTH)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (w_sr_load),
        .shift (w_sr_shift),
        .din   (w_sr_din),
        .dout  (w_sr_dout),
        .dnext (w_sr_dnext)
    );

    // Next-state, counters and next value of every registered output.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        rep_cnt_d   = rep_cnt_q;
        word_d      = word_q;
        final_d     = final_q;
        out_d       = IDLE_BIT;
        out_valid_d = 1'b0;
        done_d      = 1'b0;
        w_sr_load   = 1'b0;
        w_sr_shift  = 1'b0;
        w_sr_din    = word_q;

        unique case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    state_d     = S_SHIFT;
                    word_d      = bus.load_data;
                    w_sr_din    = bus.load_data;
                    w_sr_load   = 1'b1;
                    rep_cnt_d   = bus.load_rep;
                    bit_cnt_d   = '0;
                    final_d     = 1'b0;
                    out_d       = bus.load_data[WIDTH-1];
                    out_valid_d = 1'b1;
                end
            end

            S_SHIFT: begin
                if (bit_cnt_q != c_bit_last) begin
                    // Mid-word: the bit below the current MSB goes out next.
                    w_sr_shift  = 1'b1;
                    bit_cnt_d   = bit_cnt_q + c_bit_one;
                    out_d       = w_sr_dnext;
                    out_valid_d = 1'b1;
                end else if (rep_cnt_q != '0) begin
                    // Word finished with repetitions pending: rearm from the
                    // stored word, either seamlessly or after the gap.
                    rep_cnt_d = rep_cnt_q - c_rep_one;
                    w_sr_load = 1'b1;
                    bit_cnt_d = '0;
                    if (GAP == 0) begin
                        out_d       = word_q[WIDTH-1];
                        out_valid_d = 1'b1;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                    end
                end else begin
                    // Final word finished.
                    done_d = 1'b1;
                    if (GAP == 0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_GAP;
                        gap_cnt_d = '0;
                        final_d   = 1'b1;
                    end
                end
            end

            S_GAP: begin
                if (gap_cnt_q == c_gap_last) begin
                    if (final_q) begin
                        state_d = S_IDLE;
                    end else begin
                        // Shift register was reloaded on entry to the gap.
                        state_d     = S_SHIFT;
                        bit_cnt_d   = '0;
                        out_d       = w_sr_dout;
                        out_valid_d = 1'b1;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + c_gap_one;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= '0;
            gap_cnt_q   <= '0;
            rep_cnt_q   <= '0;
            word_q      <= '0;
            final_q     <= 1'b0;
            out_q       <= IDLE_BIT;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            rep_cnt_q   <= rep_cnt_d;
            word_q      <= word_d;
            final_q     <= final_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
        end
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_seq_stim_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_stim_tx
//  Description : Directed bench for seq_stim_tx. Two instances, WIDTH=8 with
//                GAP=0 and GAP=2. Expected waveforms come from the timing
//                formulas of the transmitter (word r at cycles
//                k+1+r*(W+G) .. k+r*(W+G)+W after accept edge k).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_seq_stim_tx;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    seq_stim_tx_if #(.WIDTH(8)) if0 ();
    seq_stim_tx_if #(.WIDTH(8)) if2 ();

    seq_stim_tx #(.WIDTH(8), .GAP(0), .IDLE_BIT(1'b0)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0)
    );

    seq_stim_tx #(.WIDTH(8), .GAP(2), .IDLE_BIT(1'b0)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (if2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {out, out_valid, busy, done} in cycle k+t after accept edge k.
    function automatic logic [3:0] exp_sig(input logic [7:0] d, input int rep,
                                           input int gap, input int t);
        int   per;
        int   r;
        int   p;
        logic o;
        logic v;
        logic b;
        logic dn;
        per = 8 + gap;
        b   = (t >= 1) && (t <= (rep + 1) * per);
        dn  = (t == (rep + 1) * 8 + rep * gap + 1);
        o   = 1'b0;
        v   = 1'b0;
        if (t >= 1) begin
            r = (t - 1) / per;
            p = (t - 1) % per;
            if (r <= rep && p < 8) begin
                v = 1'b1;
                o = d[7 - p];
            end
        end
        return {o, v, b, dn};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        if0.load_valid = 1'b0; if0.load_data = '0; if0.load_rep = '0;
        if2.load_valid = 1'b0; if2.load_data = '0; if2.load_rep = '0;
        repeat (2) tick();
        total++;
        if ({if0.load_ready, if2.load_ready} !== 2'b00) begin
            bad++;
            $display("FAIL reset_ready_low got=%b exp=00", {if0.load_ready, if2.load_ready});
        end
        total++;
        if ({if0.out, if0.out_valid, if0.busy, if0.done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_out0 got=%b exp=0000", {if0.out, if0.out_valid, if0.busy, if0.done});
        end
        total++;
        if ({if2.out, if2.out_valid, if2.busy, if2.done} !== 4'b0000) begin
            bad++;
            $display("FAIL reset_out2 got=%b exp=0000", {if2.out, if2.out_valid, if2.busy, if2.done});
        end
        rst = 1'b0;
        #1;
        total++;
        if ({if0.load_ready, if2.load_ready} !== 2'b11) begin
            bad++;
            $display("FAIL reset_ready_high got=%b exp=11", {if0.load_ready, if2.load_ready});
        end
        tick();
    endtask

    task automatic test_single();
        logic [4:0] got;
        logic [3:0] e;
        if0.load_valid = 1'b1; if0.load_data = 8'hB4; if0.load_rep = 4'd0;
        tick();
        if0.load_valid = 1'b0; if0.load_data = 8'hFF;
        for (int t = 1; t <= 9; t++) begin
            e   = exp_sig(8'hB4, 0, 0, t);
            got = {if0.out, if0.out_valid, if0.busy, if0.done, if0.load_ready};
            total++;
            if (got !== {e, ~e[1]}) begin
                bad++;
                $display("FAIL single t=%0d got=%b exp=%b", t, got, {e, ~e[1]});
            end
            if (t < 9) tick();
        end
    endtask

    task automatic test_gap();
        logic [4:0] got;
        logic [3:0] e;
        int         busy_cnt;
        int         done_cnt;
        int         done_at;
        busy_cnt = 0; done_cnt = 0; done_at = -1;
        if2.load_valid = 1'b1; if2.load_data = 8'h0F; if2.load_rep = 4'd2;
        tick();
        if2.load_valid = 1'b0; if2.load_rep = 4'd9;
        for (int t = 1; t <= 31; t++) begin
            e   = exp_sig(8'h0F, 2, 2, t);
            got = {if2.out, if2.out_valid, if2.busy, if2.done, if2.load_ready};
            if (if2.busy === 1'b1) busy_cnt++;
            if (if2.done === 1'b1) begin
                done_cnt++;
                done_at = t;
            end
            total++;
            if (got !== {e, ~e[1]}) begin
                bad++;
                $display("FAIL gap t=%0d got=%b exp=%b", t, got, {e, ~e[1]});
            end
            if (t < 31) tick();
        end
        total++;
        if (busy_cnt != 30) begin
            bad++;
            $display("FAIL gap_busy_len got=%0d exp=30", busy_cnt);
        end
        total++;
        if (done_cnt != 1 || done_at != 29) begin
            bad++;
            $display("FAIL gap_done got_count=%0d got_at=%0d exp_count=1 exp_at=29", done_cnt, done_at);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] got;
        logic [3:0] e;
        int         run;
        run = 0;
        if0.load_valid = 1'b1; if0.load_data = 8'hA5; if0.load_rep = 4'd1;
        tick();
        if0.load_valid = 1'b0;
        for (int t = 1; t <= 17; t++) begin
            e   = exp_sig(8'hA5, 1, 0, t);
            got = {if0.out, if0.out_valid, if0.busy, if0.done, if0.load_ready};
            if (t <= 16 && if0.out_valid === 1'b1) run++;
            total++;
            if (got !== {e, ~e[1]}) begin
                bad++;
                $display("FAIL b2b t=%0d got=%b exp=%b", t, got, {e, ~e[1]});
            end
            if (t < 17) tick();
        end
        total++;
        if (run != 16) begin
            bad++;
            $display("FAIL b2b_contiguous got=%0d exp=16", run);
        end
    endtask

    task automatic test_rst_mid();
        logic [4:0] got;
        logic [3:0] e;
        int         done_cnt;
        int         busy_cnt;
        done_cnt = 0; busy_cnt = 0;
        if0.load_valid = 1'b1; if0.load_data = 8'hC3; if0.load_rep = 4'd3;
        tick();
        if0.load_valid = 1'b0;
        for (int t = 1; t <= 4; t++) begin
            e   = exp_sig(8'hC3, 3, 0, t);
            got = {if0.out, if0.out_valid, if0.busy, if0.done, if0.load_ready};
            total++;
            if (got !== {e, ~e[1]}) begin
                bad++;
                $display("FAIL rst_mid_pre t=%0d got=%b exp=%b", t, got, {e, ~e[1]});
            end
            if (t < 4) tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        got = {if0.out, if0.out_valid, if0.busy, if0.done, if0.load_ready};
        total++;
        if (got !== 5'b00001) begin
            bad++;
            $display("FAIL rst_mid_after got=%b exp=00001", got);
        end
        for (int i = 0; i < 40; i++) begin
            tick();
            if (if0.done !== 1'b0) done_cnt++;
            if (if0.busy !== 1'b0) busy_cnt++;
        end
        total++;
        if (done_cnt != 0 || busy_cnt != 0) begin
            bad++;
            $display("FAIL rst_mid_quiet got_done=%0d got_busy=%0d exp=0", done_cnt, busy_cnt);
        end
        if0.load_valid = 1'b1; if0.load_data = 8'h6E; if0.load_rep = 4'd0;
        tick();
        if0.load_valid = 1'b0;
        for (int t = 1; t <= 9; t++) begin
            e   = exp_sig(8'h6E, 0, 0, t);
            got = {if0.out, if0.out_valid, if0.busy, if0.done, if0.load_ready};
            total++;
            if (got !== {e, ~e[1]}) begin
                bad++;
                $display("FAIL rst_mid_fresh t=%0d got=%b exp=%b", t, got, {e, ~e[1]});
            end
            if (t < 9) tick();
        end
    endtask

    task automatic test_busy_ignore();
        logic [4:0] got;
        logic [3:0] e;
        if0.load_valid = 1'b1; if0.load_data = 8'h96; if0.load_rep = 4'd0;
        tick();
        for (int t = 1; t <= 9; t++) begin
            e   = exp_sig(8'h96, 0, 0, t);
            got = {if0.out, if0.out_valid, if0.busy, if0.done, if0.load_ready};
            total++;
            if (got !== {e, ~e[1]}) begin
                bad++;
                $display("FAIL busy_ignore t=%0d got=%b exp=%b", t, got, {e, ~e[1]});
            end
            if (t < 9) begin
                if0.load_data = 8'($urandom);
                if0.load_rep  = 4'($urandom_range(0, 15));
                tick();
            end
        end
        if0.load_valid = 1'b0;
        tick();
        total++;
        if ({if0.busy, if0.out_valid} !== 2'b00) begin
            bad++;
            $display("FAIL busy_ignore_no_extra got=%b exp=00", {if0.busy, if0.out_valid});
        end
    endtask

    task automatic test_rst_accept();
        if0.load_valid = 1'b1; if0.load_data = 8'hFF; if0.load_rep = 4'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        if0.load_valid = 1'b0;
        #1;
        total++;
        if ({if0.busy, if0.out_valid, if0.load_ready} !== 3'b001) begin
            bad++;
            $display("FAIL rst_accept got=%b exp=001", {if0.busy, if0.out_valid, if0.load_ready});
        end
        tick();
        total++;
        if ({if0.busy, if0.out_valid, if0.out} !== 3'b000) begin
            bad++;
            $display("FAIL rst_accept_next got=%b exp=000", {if0.busy, if0.out_valid, if0.out});
        end
    endtask

    task automatic test_random();
        logic [7:0] d0;
        logic [7:0] d2;
        int         r0;
        int         r2;
        int         last;
        logic [4:0] got0;
        logic [4:0] got2;
        logic [3:0] e0;
        logic [3:0] e2;
        for (int n = 0; n < 6; n++) begin
            d0 = 8'($urandom);
            d2 = 8'($urandom);
            r0 = $urandom_range(0, 2);
            r2 = $urandom_range(0, 2);
            last = ((r0 + 1) * 8 > (r2 + 1) * 10) ? (r0 + 1) * 8 + 1 : (r2 + 1) * 10 + 1;
            if0.load_valid = 1'b1; if0.load_data = d0; if0.load_rep = 4'(r0);
            if2.load_valid = 1'b1; if2.load_data = d2; if2.load_rep = 4'(r2);
            tick();
            if0.load_valid = 1'b0;
            if2.load_valid = 1'b0;
            for (int t = 1; t <= last; t++) begin
                e0   = exp_sig(d0, r0, 0, t);
                e2   = exp_sig(d2, r2, 2, t);
                got0 = {if0.out, if0.out_valid, if0.busy, if0.done, if0.load_ready};
                got2 = {if2.out, if2.out_valid, if2.busy, if2.done, if2.load_ready};
                total++;
                if (got0 !== {e0, ~e0[1]}) begin
                    bad++;
                    $display("FAIL random_g0 n=%0d t=%0d d=%h rep=%0d got=%b exp=%b",
                             n, t, d0, r0, got0, {e0, ~e0[1]});
                end
                total++;
                if (got2 !== {e2, ~e2[1]}) begin
                    bad++;
                    $display("FAIL random_g2 n=%0d t=%0d d=%h rep=%0d got=%b exp=%b",
                             n, t, d2, r2, got2, {e2, ~e2[1]});
                end
                if (t < last) tick();
            end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        test_reset();
        test_single();
        test_gap();
        test_back_to_back();
        test_rst_mid();
        test_busy_ignore();
        test_rst_accept();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
